// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of an N_IN-input combinational block, captures its truth table and
// compares it against a latched expected table. Optional first-failure capture: TTS_FIRST_FAIL_EN.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1,
    localparam int TW    = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [TW-1:0]   expected,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TW-1:0]   table_q,
    output logic [N_IN:0]   mismatches,
    output logic [N_IN-1:0] first_fail
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    state_t          state;
    logic [TW-1:0]   expected_q;
    logic [CW-1:0]   cnt;
    logic            exp_bit;
    logic            hit;
    logic            miss;
    logic            last;
    logic [N_IN:0]   mism_next;

    // Case equality so an X/Z response is stored as 0 and always counts as a mismatch.
    assign exp_bit   = expected_q[dut_in];
    assign hit       = (dut_out === 1'b1);
    assign miss      = (dut_out !== exp_bit);
    assign last      = (dut_in == N_IN'(TW - 1));
    assign mism_next = mismatches + {{N_IN{1'b0}}, miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            expected_q <= '0;
            cnt        <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            table_q    <= '0;
            mismatches <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        expected_q <= expected;
                        table_q    <= '0;
                        mismatches <= '0;
                        pass       <= 1'b0;
                        dut_in     <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt == CW'(SETTLE - 1)) state <= SAMPLE;
                    else                        cnt   <= cnt + 1'b1;
                end
                SAMPLE: begin
                    table_q[dut_in] <= hit;
                    mismatches      <= mism_next;
                    if (last) begin
                        done  <= 1'b1;
                        pass  <= (mism_next == '0);
                        state <= FINISH;
                    end else begin
                        dut_in <= dut_in + 1'b1;
                        cnt    <= '0;
                        state  <= DRIVE;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TTS_FIRST_FAIL_EN
    // No mismatch counted yet this sweep means the current miss is the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            first_fail <= '0;
        else if (state == IDLE && start)
            first_fail <= '0;
        else if (state == SAMPLE && miss && mismatches == '0)
            first_fail <= dut_in;
    end
`else
    assign first_fail = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a 3-input/SETTLE=1 instance and a 4-input/SETTLE=3 instance.
module tb_truth_table_sweeper;

`ifdef TTS_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] tq;
        int          mm;
        bit          ps;
        int          ff;
        int          c0;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 1: N_IN=3, SETTLE=1
    logic       start1 = 1'b0;
    logic [7:0] expected1 = '0;
    logic [2:0] dut_in1;
    logic       dut_out1;
    logic       busy1, done1, pass1;
    logic [7:0] table_q1;
    logic [3:0] mismatches1;
    logic [2:0] first_fail1;
    logic       dut_sel = 1'b0;
    logic [7:0] alt_tab = 8'h27;

    // Instance 2: N_IN=4, SETTLE=3
    logic        start2 = 1'b0;
    logic [15:0] expected2 = '0;
    logic [3:0]  dut_in2;
    logic        dut_out2;
    logic        busy2, done2, pass2;
    logic [15:0] table_q2;
    logic [4:0]  mismatches2;
    logic [3:0]  first_fail2;

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1),
        .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .table_q(table_q1), .mismatches(mismatches1), .first_fail(first_fail1)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2),
        .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2),
        .table_q(table_q2), .mismatches(mismatches2), .first_fail(first_fail2)
    );

    // Logic under test: sel=0 is !A!B + !BC + B!C (table 8'h67), sel=1 is a block with table 8'h27.
    always_comb begin
        dut_out1 = 1'b0;
        if (dut_sel) dut_out1 = alt_tab[dut_in1];
        else dut_out1 = (~dut_in1[2] & ~dut_in1[1]) | (~dut_in1[1] & dut_in1[0]) | (dut_in1[1] & ~dut_in1[0]);
    end

    // 4-input odd parity: table 16'h6996.
    assign dut_out2 = ^dut_in2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done1) begin
            chk("d1_done_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                m1 = q1.pop_front();
                chk("d1_latency", cyc - m1.c0, m1.lat);
                chk("d1_table_q", {24'h0, table_q1}, {16'h0, m1.tq});
                chk("d1_mismatches", {28'h0, mismatches1}, m1.mm);
                chk("d1_pass", {31'h0, pass1}, {31'h0, m1.ps});
                chk("d1_first_fail", {29'h0, first_fail1}, m1.ff);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done2) begin
            chk("d2_done_expected", 32'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                m2 = q2.pop_front();
                chk("d2_latency", cyc - m2.c0, m2.lat);
                chk("d2_table_q", {16'h0, table_q2}, {16'h0, m2.tq});
                chk("d2_mismatches", {27'h0, mismatches2}, m2.mm);
                chk("d2_pass", {31'h0, pass2}, {31'h0, m2.ps});
                chk("d2_first_fail", {28'h0, first_fail2}, m2.ff);
            end
        end
    end

    // Each vector is driven for SETTLE cycles plus the sample cycle: 4 cycles on instance 2.
    int         run2 = 0;
    logic [3:0] prev2 = '0;
    always @(negedge clk) begin
        if (busy2) begin
            if (run2 > 0 && dut_in2 != prev2) begin
                chk("t6_hold_cycles", run2, 4);
                run2 = 1;
            end else begin
                run2++;
            end
            prev2 = dut_in2;
        end else begin
            run2 = 0;
        end
    end

    task automatic check_zero1(input string tag);
        chk({tag, "_dut_in"}, {29'h0, dut_in1}, 0);
        chk({tag, "_busy"}, {31'h0, busy1}, 0);
        chk({tag, "_done"}, {31'h0, done1}, 0);
        chk({tag, "_pass"}, {31'h0, pass1}, 0);
        chk({tag, "_table_q"}, {24'h0, table_q1}, 0);
        chk({tag, "_mismatches"}, {28'h0, mismatches1}, 0);
        chk({tag, "_first_fail"}, {29'h0, first_fail1}, 0);
    endtask

    task automatic start_sweep1(input logic [7:0] exp_tab, input bit sel, input logic [7:0] tq,
                                input int mm, input int ff);
        exp_t e;
        @(negedge clk);
        dut_sel   = sel;
        expected1 = exp_tab;
        start1    = 1'b1;
        @(posedge clk);
        #1;
        e.tq  = {8'h0, tq};
        e.mm  = mm;
        e.ps  = (mm == 0);
        e.ff  = FF_EN ? ff : 0;
        e.c0  = cyc;
        e.lat = 16;
        q1.push_back(e);
        @(negedge clk);
        expected1 = ~exp_tab;
    endtask

    task automatic sweep1(input logic [7:0] exp_tab, input bit sel, input logic [7:0] tq,
                          input int mm, input int ff, input bit hold);
        int n;
        start_sweep1(exp_tab, sel, tq, mm, ff);
        if (!hold) start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("d1_done_timeout", 32'(n < 100), 1);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("d1_busy_after_done", {31'h0, busy1}, 0);
    endtask

    initial begin
        int n;
        exp_t e;
        repeat (2) @(negedge clk);
        check_zero1("reset1");
        chk("reset2_busy", {31'h0, busy2}, 0);
        chk("reset2_dut_in", {28'h0, dut_in2}, 0);
        chk("reset2_table_q", {16'h0, table_q2}, 0);
        rst_n = 1'b1;

        // T1: matching table
        sweep1(8'h67, 1'b0, 8'h67, 0, 0, 1'b0);
        // T2: expected bit 0 wrong
        sweep1(8'h66, 1'b0, 8'h67, 1, 0, 1'b0);
        // T3: DUT differs from expectation only at index 6
        sweep1(8'h67, 1'b1, 8'h27, 1, 6, 1'b0);
        // T4: start held for the whole sweep; the monitor flags any second done
        sweep1(8'h67, 1'b0, 8'h67, 0, 0, 1'b1);
        repeat (20) @(negedge clk);
        chk("t4_no_restart", {31'h0, busy1}, 0);

        // T5: reset while dut_in == 3
        start_sweep1(8'h67, 1'b0, 8'h67, 0, 0);
        start1 = 1'b0;
        n = 0;
        while (dut_in1 != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_3", 32'(n < 100), 1);
        rst_n = 1'b0;
        #1;
        check_zero1("t5_reset");
        e = q1.pop_back();
        repeat (3) @(negedge clk);
        chk("t5_no_done", {31'h0, done1}, 0);
        rst_n = 1'b1;
        sweep1(8'h67, 1'b0, 8'h67, 0, 0, 1'b0);

        // T6: 4-input parity, SETTLE=3
        @(negedge clk);
        expected2 = 16'h6996;
        start2    = 1'b1;
        @(posedge clk);
        #1;
        e.tq  = 16'h6996;
        e.mm  = 0;
        e.ps  = 1'b1;
        e.ff  = 0;
        e.c0  = cyc;
        e.lat = 64;
        q2.push_back(e);
        @(negedge clk);
        start2    = 1'b0;
        expected2 = 16'h0;
        n = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("d2_done_timeout", 32'(n < 200), 1);
        repeat (4) @(negedge clk);
        chk("d2_busy_after_done", {31'h0, busy2}, 0);

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
